serial_row_loader: RTL and testbench

- Receive end of the serial dataset load link feeding the SGD core.
- The host shifts each data point as (feat+1) 16-bit words: word index feat first, down to index 0, each word LSB first, one bit per sampled clock.
- The block deserialises the words and assembles one row per data point. Each completed row is written as one wide word into the dataset memory at address = row number.
- It raises a done flag after row data_points has been written, so the SGD engine can start.

---
 rtl/serial_row_loader.sv | 154 +++++++++++++++
 tb/tb_serial_row_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_row_loader.sv
// Deserialises LSB-first words from the host load link and writes one assembled row per data point.
// Latency: wr_en is registered one cycle after the last bit of a row is sampled; s_valid=0 stalls everything.
`timescale 1ns/1ps

module serial_row_loader #(
    parameter int LENGTH       = 16,
    parameter int MAX_FEATURES = 15,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  S,
    input  logic                  s_valid,
    input  logic                  start,
    input  logic [3:0]            feat,
    input  logic [ADDR_WIDTH-1:0] data_points,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  load_done
);

    localparam int CNT_W = $clog2(LENGTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_feat_q;
    logic [ADDR_WIDTH-1:0]   r_dp_q;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [3:0]              r_word_idx;
    logic [ADDR_WIDTH-1:0]   r_row_cnt;
    logic [LENGTH-1:0]       r_word_sr;
    logic [DATA_WIDTH-1:0]   r_row_buf;
    logic                    r_wr_en;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [DATA_WIDTH-1:0]   r_wr_data;

    logic                    w_arm;
    logic                    w_take;
    logic                    w_word_done;
    logic                    w_row_done;
    logic                    w_last_row;
    logic [LENGTH-1:0]       w_new_word;
    logic [DATA_WIDTH-1:0]   w_row_merged;

    // start only arms a load outside RECV; a pulse mid-load is ignored
    assign w_arm       = start && (r_state != RECV);
    assign w_take      = (r_state == RECV) && s_valid;
    assign w_new_word  = {S, r_word_sr[LENGTH-1:1]};
    assign w_word_done = w_take && (r_bit_cnt == LAST_BIT);
    assign w_row_done  = w_word_done && (r_word_idx == 4'd0);
    assign w_last_row  = w_row_done && (r_row_cnt == r_dp_q);

    always_comb begin
        w_row_merged = r_row_buf;
        w_row_merged[r_word_idx*LENGTH +: LENGTH] = w_new_word;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        load_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RECV;
                end
            end
            RECV: begin
                busy = 1'b1;
                if (w_last_row) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                load_done = 1'b1;
                if (start) begin
                    w_state_nxt = RECV;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_feat_q   <= '0;
            r_dp_q     <= '0;
            r_bit_cnt  <= '0;
            r_word_idx <= '0;
            r_row_cnt  <= '0;
            r_word_sr  <= '0;
            r_row_buf  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_arm) begin
                r_feat_q   <= feat;
                r_dp_q     <= data_points;
                r_bit_cnt  <= '0;
                r_word_idx <= feat;
                r_row_cnt  <= '0;
                r_word_sr  <= '0;
                r_row_buf  <= '0;
            end else if (w_take) begin
                r_word_sr <= w_new_word;
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                if (w_word_done) begin
                    r_bit_cnt <= '0;
                    if (r_word_idx != 4'd0) begin
                        r_word_idx <= r_word_idx - 4'd1;
                        r_row_buf  <= w_row_merged;
                    end else begin
                        // row complete: final word goes straight to the write port
                        r_wr_data  <= w_row_merged;
                        r_wr_addr  <= r_row_cnt;
                        r_wr_en    <= 1'b1;
                        r_row_buf  <= '0;
                        r_word_idx <= r_feat_q;
                        if (r_row_cnt != r_dp_q) begin
                            r_row_cnt <= r_row_cnt + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_serial_row_loader.sv
// Randomised bench for serial_row_loader: rows are built as word arrays, shifted out bit by bit, and checked against a write queue.
`timescale 1ns/1ps

module tb_serial_row_loader;

    localparam int AW = 12;
    localparam int DW = 256;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          S = 1'b0;
    logic          s_valid = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    feat = 4'd0;
    logic [AW-1:0] data_points = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          load_done;

    serial_row_loader dut (
        .CLK         (CLK),
        .RST         (RST),
        .S           (S),
        .s_valid     (s_valid),
        .start       (start),
        .feat        (feat),
        .data_points (data_points),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .load_done   (load_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            last;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_err = 0;
    int  n_wr  = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Every write must land exactly one cycle after its row's final bit
    always @(negedge CLK) begin
        if (wr_en === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("extra_wr", DW'(wr_en), '0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", DW'(wr_addr), DW'(mon_e.addr));
                chk("wr_data", wr_data, mon_e.data);
                chk("done_at_wr", DW'(load_done), DW'(mon_e.last));
                chk("busy_at_wr", DW'(busy), DW'(!mon_e.last));
            end
        end else if (exp_q.size() != 0) begin
            chk("wr_latency", DW'(wr_en), DW'(1));
            void'(exp_q.pop_front());
        end
    end

    task automatic do_start(input int f, input int d);
        start       = 1'b1;
        feat        = 4'(f);
        data_points = AW'(d);
        s_valid     = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        chk("busy_after_start", DW'(busy), DW'(1));
        chk("done_after_start", DW'(load_done), '0);
    endtask

    // Host order: word f first down to word 0, each LSB first
    task automatic send_row(input int f, input logic [15:0] w[16], input int addr, input bit last,
                            input int stall_pct, input int pulse_at, input int max_bits);
        logic [DW-1:0] d;
        wr_t           e;
        int            k;
        d = '0;
        for (int j = 0; j <= f; j++) d[16*j +: 16] = w[j];
        k = 0;
        for (int j = f; j >= 0; j--) begin
            for (int b = 0; b < 16; b++) begin
                if (k < max_bits) begin
                    while (32'($urandom_range(99)) < 32'(stall_pct)) begin
                        s_valid = 1'b0;
                        S       = 1'($urandom);
                        @(negedge CLK);
                    end
                    start = (k == pulse_at);
                    if (start) begin
                        feat        = 4'd5;
                        data_points = '0;
                    end
                    S       = w[j][b];
                    s_valid = 1'b1;
                    @(posedge CLK);
                    if (j == 0 && b == 15) begin
                        e.addr = AW'(addr);
                        e.data = d;
                        e.last = last;
                        exp_q.push_back(e);
                    end
                    @(negedge CLK);
                    k++;
                end
            end
        end
        start   = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic check_end(input string tag, input int base, input int n_exp);
        @(negedge CLK);
        chk({tag, "_count"}, DW'(n_wr - base), DW'(n_exp));
        chk({tag, "_qempty"}, DW'(exp_q.size()), '0);
        chk({tag, "_done"}, DW'(load_done), DW'(1));
        chk({tag, "_busy"}, DW'(busy), '0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_wr_en"}, DW'(wr_en), '0);
        chk({tag, "_wr_addr"}, DW'(wr_addr), '0);
        chk({tag, "_wr_data"}, wr_data, '0);
        chk({tag, "_busy"}, DW'(busy), '0);
        chk({tag, "_done"}, DW'(load_done), '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w[16];
        int          base;

        for (int j = 0; j < 16; j++) w[j] = '0;
        repeat (3) @(negedge CLK);
        check_reset_outs("rst");
        RST = 1'b1;
        @(negedge CLK);

        // Two-word single row, continuous valid
        base = n_wr;
        do_start(1, 0);
        w[1] = 16'h1234;
        w[0] = 16'hABCD;
        send_row(1, w, 0, 1'b1, 0, -1, 999);
        check_end("s1", base, 1);

        // 100 rows of 15 random words
        base = n_wr;
        do_start(14, 99);
        for (int r = 0; r < 100; r++) begin
            for (int j = 0; j < 16; j++) w[j] = (j <= 14) ? 16'($urandom) : 16'h0;
            send_row(14, w, r, r == 99, 0, -1, 999);
        end
        check_end("s2", base, 100);

        // Scenario 1 again with ~50% s_valid
        base = n_wr;
        do_start(1, 0);
        for (int j = 0; j < 16; j++) w[j] = '0;
        w[1] = 16'h1234;
        w[0] = 16'hABCD;
        send_row(1, w, 0, 1'b1, 50, -1, 999);
        check_end("s3", base, 1);

        // Reset 20 bits into row 3 drops the partial row
        base = n_wr;
        do_start(1, 5);
        for (int r = 0; r < 3; r++) begin
            w[1] = 16'($urandom);
            w[0] = 16'($urandom);
            send_row(1, w, r, 1'b0, 25, -1, 999);
        end
        send_row(1, w, 3, 1'b0, 0, -1, 20);
        RST = 1'b0;
        #1;
        check_reset_outs("midrst");
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("s4a_count", DW'(n_wr - base), DW'(3));
        base = n_wr;
        do_start(0, 1);
        w[0] = 16'h00FF;
        send_row(0, w, 0, 1'b0, 0, -1, 999);
        w[0] = 16'hFF00;
        send_row(0, w, 1, 1'b1, 0, -1, 999);
        check_end("s4", base, 2);

        // Bits in IDLE ignored; mid-RECV start ignored; feat changes after start ignored
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        base = n_wr;
        for (int i = 0; i < 40; i++) begin
            S       = 1'($urandom);
            s_valid = 1'b1;
            @(negedge CLK);
        end
        s_valid = 1'b0;
        chk("idle_busy", DW'(busy), '0);
        chk("idle_count", DW'(n_wr - base), '0);
        do_start(2, 1);
        feat        = 4'd7;
        data_points = AW'(3);
        for (int j = 0; j < 16; j++) w[j] = (j <= 2) ? 16'($urandom) : 16'h0;
        send_row(2, w, 0, 1'b0, 20, 10, 999);
        for (int j = 0; j < 16; j++) w[j] = (j <= 2) ? 16'($urandom) : 16'h0;
        send_row(2, w, 1, 1'b1, 20, -1, 999);
        check_end("s5", base, 2);

        // Re-arm from DONE
        base = n_wr;
        do_start(2, 0);
        w[2] = 16'hC0DE;
        w[1] = 16'h5A5A;
        w[0] = 16'h0001;
        send_row(2, w, 0, 1'b1, 0, -1, 999);
        check_end("s6", base, 1);

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
